// File: rtl/h8_dmem_pkg.sv
// Shared constants and types for the h8 data-memory responder.
package h8_dmem_pkg;

    localparam logic [7:0]  MMIO_BASE = 8'hF0;
    localparam int unsigned RAM_BYTES = 240;

    localparam logic [3:0] OFF_CNT_LO  = 4'h0;
    localparam logic [3:0] OFF_CNT_HI  = 4'h1;
    localparam logic [3:0] OFF_CMP     = 4'h2;
    localparam logic [3:0] OFF_TCTL    = 4'h3;
    localparam logic [3:0] OFF_SCRATCH = 4'h4;
    localparam logic [3:0] OFF_TXDATA  = 4'h8;
    localparam logic [3:0] OFF_TXSTAT  = 4'h9;

    localparam int unsigned TCTL_EN_BIT     = 0;
    localparam int unsigned TCTL_PEND_BIT   = 1;
    localparam int unsigned TXSTAT_FULL_BIT = 3;
    localparam int unsigned TXSTAT_BUSY_BIT = 4;
    localparam int unsigned TXSTAT_OVF_BIT  = 5;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

endpackage

// File: rtl/h8_dmem_responder_uart_tx.sv
// UART serializer: 8N1 frames, LSB first, byte taken over a valid/ready handshake.
module h8_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_tx
);
    import h8_dmem_pkg::*;

    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    uart_state_e      state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             baud_end;

    assign baud_end = (baud_q == BaudW'(CLKS_PER_BIT - 1));
    assign o_ready  = (state_q == StIdle);
    assign o_busy   = (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        o_tx    = 1'b1;
        case (state_q)
            StIdle: begin
                if (i_valid) begin
                    state_d = StStart;
                    shift_d = i_data;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            StStart: begin
                o_tx = 1'b0;
                if (baud_end) begin
                    state_d = StData;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                o_tx = shift_q[0];
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StStop: begin
                if (baud_end) begin
                    state_d = StIdle;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/h8_dmem_responder.sv
// h8 dmem responder: 240-byte RAM plus MMIO counter/timer/scratch/UART window.
// UART FIFO and serializer are built only when H8_DMEM_UART_EN is defined.
module h8_dmem_responder #(
    parameter int unsigned CLKS_PER_BIT  = 16,
    parameter int unsigned TX_FIFO_DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_req_addr,
    input  logic [7:0] i_req_data,
    input  logic       i_req_write,
    input  logic       i_req_valid,
    output logic [7:0] o_rsp_data,
    output logic       o_tx,
    output logic       o_irq
);
    import h8_dmem_pkg::*;

    logic       req_rd, req_wr, is_mmio;
    logic [3:0] off;
    logic       rd_cnt_lo, wr_cmp, wr_tctl, wr_scratch;

    assign req_rd     = i_req_valid & ~i_req_write;
    assign req_wr     = i_req_valid & i_req_write;
    assign is_mmio    = (i_req_addr >= MMIO_BASE);
    assign off        = i_req_addr[3:0];
    assign rd_cnt_lo  = req_rd & is_mmio & (off == OFF_CNT_LO);
    assign wr_cmp     = req_wr & is_mmio & (off == OFF_CMP);
    assign wr_tctl    = req_wr & is_mmio & (off == OFF_TCTL);
    assign wr_scratch = req_wr & is_mmio & (off == OFF_SCRATCH);

    logic [7:0] ram_q [RAM_BYTES];

    always_ff @(posedge i_clk) begin
        if (req_wr && !is_mmio) begin
            ram_q[i_req_addr] <= i_req_data;
        end
    end

    logic [15:0] cnt_q;
    logic [7:0]  shadow_q, shadow_d, cmp_q, cmp_d, scratch_q, scratch_d;
    logic [7:0]  rsp_q, rsp_d, rd_data, txstat;
    logic        en_q, en_d, pend_q, pend_d;

    always_comb begin
        shadow_d  = rd_cnt_lo ? cnt_q[15:8] : shadow_q;
        cmp_d     = wr_cmp ? i_req_data : cmp_q;
        scratch_d = wr_scratch ? i_req_data : scratch_q;
        en_d      = wr_tctl ? i_req_data[TCTL_EN_BIT] : en_q;
        pend_d    = pend_q;
        if (wr_tctl && i_req_data[TCTL_PEND_BIT]) begin
            pend_d = 1'b0;
        end
        // A match in the same cycle as a clear takes priority.
        if (en_q && (cnt_q[7:0] == cmp_q)) begin
            pend_d = 1'b1;
        end
    end

    always_comb begin
        rd_data = 8'h00;
        if (!is_mmio) begin
            rd_data = ram_q[i_req_addr];
        end else begin
            case (off)
                OFF_CNT_LO:  rd_data = cnt_q[7:0];
                OFF_CNT_HI:  rd_data = shadow_q;
                OFF_CMP:     rd_data = cmp_q;
                OFF_TCTL:    rd_data = {6'b0, pend_q, en_q};
                OFF_SCRATCH: rd_data = scratch_q;
                OFF_TXSTAT:  rd_data = txstat;
                default:     rd_data = 8'h00;
            endcase
        end
    end

    assign rsp_d = req_rd ? rd_data : rsp_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q     <= '0;
            shadow_q  <= '0;
            cmp_q     <= '0;
            scratch_q <= '0;
            en_q      <= 1'b0;
            pend_q    <= 1'b0;
            rsp_q     <= '0;
        end else begin
            cnt_q     <= cnt_q + 16'd1;
            shadow_q  <= shadow_d;
            cmp_q     <= cmp_d;
            scratch_q <= scratch_d;
            en_q      <= en_d;
            pend_q    <= pend_d;
            rsp_q     <= rsp_d;
        end
    end

    assign o_rsp_data = rsp_q;
    assign o_irq      = en_q & pend_q;

`ifdef H8_DMEM_UART_EN
    localparam int unsigned PtrW = (TX_FIFO_DEPTH > 1) ? $clog2(TX_FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(TX_FIFO_DEPTH + 1);

    logic [7:0]      fifo_q [TX_FIFO_DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] fcnt_q, fcnt_d;
    logic [3:0]      fcnt_ext;
    logic            ovf_q, ovf_d, full, empty, push, push_ok, pop;
    logic            rd_txstat, tx_ready, tx_busy;

    assign push      = req_wr & is_mmio & (off == OFF_TXDATA);
    assign rd_txstat = req_rd & is_mmio & (off == OFF_TXSTAT);
    // Full uses the pre-cycle count: a push while full drops even if a pop happens now.
    assign full      = (fcnt_q == CntW'(TX_FIFO_DEPTH));
    assign empty     = (fcnt_q == '0);
    assign push_ok   = push & ~full;
    assign pop       = tx_ready & ~empty;
    assign fcnt_ext  = 4'(fcnt_q);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fcnt_d   = fcnt_q;
        ovf_d    = ovf_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(TX_FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(TX_FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   fcnt_d = fcnt_q + 1'b1;
            2'b01:   fcnt_d = fcnt_q - 1'b1;
            default: fcnt_d = fcnt_q;
        endcase
        if (rd_txstat) begin
            ovf_d = 1'b0;
        end
        if (push && full) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        txstat                  = 8'h00;
        txstat[2:0]             = (fcnt_ext > 4'd7) ? 3'd7 : fcnt_ext[2:0];
        txstat[TXSTAT_FULL_BIT] = full;
        txstat[TXSTAT_BUSY_BIT] = tx_busy;
        txstat[TXSTAT_OVF_BIT]  = ovf_q;
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            fifo_q[wr_ptr_q] <= i_req_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fcnt_q   <= fcnt_d;
            ovf_q    <= ovf_d;
        end
    end

    h8_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_data (fifo_q[rd_ptr_q]),
        .i_valid(~empty),
        .o_ready(tx_ready),
        .o_busy (tx_busy),
        .o_tx   (o_tx)
    );
`else
    assign txstat = 8'h00;
    assign o_tx   = 1'b1;
`endif

endmodule

// File: tb/tb_h8_dmem_responder.sv
// Directed bench for h8_dmem_responder: vector table plus counter/timer/UART sequences.
`timescale 1ns/1ps
module tb_h8_dmem_responder;

    localparam int unsigned CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic       wr = 1'b0;
    logic       vld = 1'b0;
    logic [7:0] rsp;
    logic       tx;
    logic       irq;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    h8_dmem_responder #(
        .CLKS_PER_BIT (CPB),
        .TX_FIFO_DEPTH(4)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req_addr (addr),
        .i_req_data (wdata),
        .i_req_write(wr),
        .i_req_valid(vld),
        .o_rsp_data (rsp),
        .o_tx       (tx),
        .o_irq      (irq)
    );

    // Reference cycle counter: value the DUT counter holds in the current cycle.
    logic [15:0] mcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mcnt <= 16'h0000;
        else        mcnt <= mcnt + 16'd1;
    end

    // Serial receiver: samples mid-bit, discards frames interrupted by reset.
    logic [7:0] rx_q [$];
    int         rx_bad = 0;
    bit         rst_seen = 1'b0;
    logic [7:0] mon_b;
    logic       mon_stop;

    always @(negedge rst_n) rst_seen = 1'b1;

    initial begin : rx_mon
        forever begin
            @(posedge clk); #1;
            if (rst_n === 1'b1 && tx === 1'b0) begin
                rst_seen = 1'b0;
                repeat (2) begin @(posedge clk); #1; end
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) begin @(posedge clk); #1; end
                    mon_b[i] = tx;
                end
                repeat (CPB) begin @(posedge clk); #1; end
                mon_stop = tx;
                if (!rst_seen) begin
                    if (mon_stop === 1'b1) rx_q.push_back(mon_b);
                    else rx_bad++;
                end
            end
        end
    end

    typedef struct {
        logic       v;
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        logic       chk;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(input logic v, input logic w, input logic [7:0] a,
                                input logic [7:0] d, input logic chk, input logic [7:0] exp);
        vec_t r;
        r.v = v; r.w = w; r.a = a; r.d = d; r.chk = chk; r.exp = exp;
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [7:0] a, input logic [7:0] d);
        vld = v; wr = w; addr = a; wdata = d;
    endtask

    task automatic do_wr(input logic [7:0] a, input logic [7:0] d);
        drive(1'b1, 1'b1, a, d);
        cyc();
        drive(1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic do_rd(input logic [7:0] a);
        drive(1'b1, 1'b0, a, 8'h00);
        cyc();
        drive(1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    endtask

    task automatic fail_timeout(input string name, input int waited);
        n_checks++;
        $display("FAIL %s: still waiting after %0d cycles, expected event", name, waited);
    endtask

    task automatic wait_cnt(input logic [15:0] val, input logic [15:0] mask, input int bound,
                            input string name);
        int n = 0;
        while (((mcnt & mask) != (val & mask)) && n < bound) begin
            cyc();
            n++;
        end
        if ((mcnt & mask) != (val & mask)) fail_timeout(name, n);
    endtask

    task automatic wait_rx(input int want, input int bound, input string name);
        int n = 0;
        while (rx_q.size() < want && n < bound) begin
            cyc();
            n++;
        end
        if (rx_q.size() < want) fail_timeout(name, n);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [9:0]  frame;
        logic        obs [40];
        logic [3:0]  got;
        logic [7:0]  bytes6 [6];
        logic [7:0]  b;
        logic        tx_stuck;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check8("reset_rsp", rsp, 8'h00);
        check8("reset_tx", {7'b0, tx}, 8'h01);
        check8("reset_irq", {7'b0, irq}, 8'h00);
        rst_n = 1'b1;

        // Vector table: RAM and register read/write, unmapped and RO addresses
        tbl[0]  = mk(1'b1, 1'b1, 8'h10, 8'h5A, 1'b0, 8'h00);
        tbl[1]  = mk(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 8'h5A);
        tbl[2]  = mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h5A);
        tbl[3]  = mk(1'b1, 1'b1, 8'h11, 8'hC3, 1'b1, 8'h5A);
        tbl[4]  = mk(1'b1, 1'b0, 8'h11, 8'h00, 1'b1, 8'hC3);
        tbl[5]  = mk(1'b1, 1'b1, 8'hF4, 8'h77, 1'b1, 8'hC3);
        tbl[6]  = mk(1'b1, 1'b0, 8'hF4, 8'h00, 1'b1, 8'h77);
        tbl[7]  = mk(1'b1, 1'b1, 8'hF2, 8'h99, 1'b0, 8'h00);
        tbl[8]  = mk(1'b1, 1'b0, 8'hF2, 8'h00, 1'b1, 8'h99);
        tbl[9]  = mk(1'b1, 1'b1, 8'hF1, 8'hAB, 1'b0, 8'h00);
        tbl[10] = mk(1'b1, 1'b0, 8'hF1, 8'h00, 1'b1, 8'h00);
        tbl[11] = mk(1'b1, 1'b1, 8'hF5, 8'h12, 1'b0, 8'h00);
        tbl[12] = mk(1'b1, 1'b0, 8'hF5, 8'h00, 1'b1, 8'h00);
        tbl[13] = mk(1'b1, 1'b0, 8'hF3, 8'h00, 1'b1, 8'h00);
        tbl[14] = mk(1'b1, 1'b1, 8'hEF, 8'h3C, 1'b0, 8'h00);
        tbl[15] = mk(1'b1, 1'b0, 8'hEF, 8'h00, 1'b1, 8'h3C);
        tbl[16] = mk(1'b1, 1'b0, 8'hF8, 8'h00, 1'b1, 8'h00);
        tbl[17] = mk(1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 8'h00);
        tbl[18] = mk(1'b1, 1'b0, 8'hF9, 8'h00, 1'b1, 8'h00);

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d);
            cyc();
            drive(1'b0, 1'b0, 8'h00, 8'h00);
            if (tbl[i].chk) check8($sformatf("vec%0d_addr%02h", i, tbl[i].a), rsp, tbl[i].exp);
        end

        // Counter snapshot: CNT_HI returns the shadow taken by the CNT_LO read
        wait_cnt(16'h01FF, 16'hFFFF, 1000, "wait_cnt_01ff");
        do_rd(8'hF0);
        check8("cnt_lo_at_01ff", rsp, 8'hFF);
        cyc();
        check8("rsp_hold_idle", rsp, 8'hFF);
        cyc();
        do_rd(8'hF1);
        check8("cnt_hi_shadow", rsp, 8'h01);

        // Compare timer
        do_wr(8'hF2, 8'h40);
        do_wr(8'hF3, 8'h01);
        check8("irq_armed_low", {7'b0, irq}, 8'h00);
        wait_cnt(16'h0040, 16'h00FF, 300, "wait_match1");
        check8("irq_in_match_cycle", {7'b0, irq}, 8'h00);
        cyc();
        check8("irq_after_match", {7'b0, irq}, 8'h01);
        do_rd(8'hF3);
        check8("tctl_pend_en", rsp, 8'h03);
        do_wr(8'hF3, 8'h03);
        check8("irq_cleared", {7'b0, irq}, 8'h00);
        wait_cnt(16'h0040, 16'h00FF, 300, "wait_match2");
        do_wr(8'hF3, 8'h03);
        check8("irq_set_wins_clear", {7'b0, irq}, 8'h01);
        do_wr(8'hF3, 8'h02);
        check8("irq_disabled", {7'b0, irq}, 8'h00);
        do_rd(8'hF3);
        check8("tctl_after_disable", rsp, 8'h00);

        // Counter wrap
        wait_cnt(16'hFFFF, 16'hFFFF, 70000, "wait_cnt_ffff");
        do_rd(8'hF0);
        check8("cnt_lo_at_ffff", rsp, 8'hFF);
        do_rd(8'hF0);
        check8("cnt_lo_wrapped", rsp, 8'h00);
        do_rd(8'hF1);
        check8("cnt_hi_wrapped", rsp, 8'h00);

`ifdef H8_DMEM_UART_EN
        // Single frame, cycle-exact
        frame = {1'b1, 8'hA5, 1'b0};
        do_wr(8'hF8, 8'hA5);
        do_rd(8'hF9);
        check8("txstat_after_push", rsp, 8'h01);
        for (int k = 0; k < 40; k++) begin
            obs[k] = tx;
            if (k == 21) check8("txstat_busy", rsp, 8'h10);
            if (k == 20) drive(1'b1, 1'b0, 8'hF9, 8'h00);
            else drive(1'b0, 1'b0, 8'h00, 8'h00);
            cyc();
        end
        for (int j = 0; j < 10; j++) begin
            got = {obs[4*j+3], obs[4*j+2], obs[4*j+1], obs[4*j]};
            check8($sformatf("frame_a5_bit%0d", j), {4'b0, got}, {4'b0, {4{frame[j]}}});
        end
        do_rd(8'hF9);
        check8("txstat_after_frame", rsp, 8'h00);
        wait_rx(1, 20, "rx_a5");
        b = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
        check8("rx_a5", b, 8'hA5);

        // Back-to-back pushes: first pops, four queue, sixth overflows
        bytes6[0] = 8'h11; bytes6[1] = 8'h22; bytes6[2] = 8'h33;
        bytes6[3] = 8'h44; bytes6[4] = 8'h55; bytes6[5] = 8'h66;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 8'hF8, bytes6[i]);
            cyc();
        end
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        do_rd(8'hF9);
        check8("txstat_full_ovf", rsp, 8'h3C);
        do_rd(8'hF9);
        check8("txstat_ovf_cleared", rsp, 8'h1C);
        wait_rx(5, 400, "rx_five");
        for (int i = 0; i < 5; i++) begin
            b = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            check8($sformatf("rx_burst%0d", i), b, bytes6[i]);
        end
        repeat (60) cyc();
        check8("rx_no_sixth", 8'(rx_q.size()), 8'h00);
        do_rd(8'hF9);
        check8("txstat_idle_again", rsp, 8'h00);

        // Reset mid-frame
        do_wr(8'hF8, 8'hF0);
        do_wr(8'hF8, 8'h0F);
        repeat (8) cyc();
        check8("tx_data_before_reset", {7'b0, tx}, 8'h00);
        rst_n = 1'b0;
        #1;
        check8("tx_async_reset", {7'b0, tx}, 8'h01);
        check8("rsp_async_reset", rsp, 8'h00);
        repeat (3) cyc();
        rst_n = 1'b1;
        do_rd(8'hF9);
        check8("txstat_after_reset", rsp, 8'h00);
        tx_stuck = 1'b1;
        for (int k = 0; k < 120; k++) begin
            if (tx !== 1'b1) tx_stuck = 1'b0;
            cyc();
        end
        check8("tx_idle_after_reset", {7'b0, tx_stuck}, 8'h01);
        check8("rx_no_frame_after_reset", 8'(rx_q.size()), 8'h00);
`else
        do_wr(8'hF8, 8'hA5);
        do_rd(8'hF9);
        check8("txstat_disabled", rsp, 8'h00);
        tx_stuck = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (tx !== 1'b1) tx_stuck = 1'b0;
            cyc();
        end
        check8("tx_tied_high", {7'b0, tx_stuck}, 8'h01);
`endif

        check8("rx_framing_errors", 8'(rx_bad), 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/h8_dmem_responder.md
# h8_dmem_responder

Data-memory responder for the h8 core's single-port request interface. Occupies the core's dmem port in place of a plain RAM. Decodes the 8-bit address space into a 240-byte RAM region and a 16-byte MMIO window. The window holds a free-running cycle counter, a compare timer with interrupt, a scratch register and a FIFO-buffered UART transmitter.

## Interface
Parameters:
- CLKS_PER_BIT, 16: UART bit period in i_clk cycles (≥2).
- TX_FIFO_DEPTH, 4: UART TX FIFO entries (power of two, ≤8).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_req_addr  in  8  request address.
- i_req_data  in  8  write data.
- i_req_write  in  1  1 = write, 0 = read; qualified by i_req_valid.
- i_req_valid  in  1  request strobe; one request per cycle, no backpressure.
- o_rsp_data  out  8  read response.
- o_tx  out  1  UART serial output, idle high.
- o_irq  out  1  timer interrupt, level.

## Operation
Address map:
- 0x00–0xEF: RAM. Contents not reset.
- 0xF0 CNT_LO (RO): low byte of the 16-bit cycle counter. A read also snapshots the high byte into a shadow register.
- 0xF1 CNT_HI (RO): returns the shadow, not the live high byte.
- 0xF2 CMP (RW).
- 0xF3 TCTL: bit0 EN (RW); bit1 PEND (write 1 to clear); other bits read 0.
- 0xF4 SCRATCH (RW).
- 0xF8 TXDATA (WO): a write pushes one byte to the FIFO. Reads return 0.
- 0xF9 TXSTAT (RO): [2:0] FIFO count (saturates at 7), [3] full, [4] serializer busy, [5] overflow. Reading clears overflow.
- All other addresses: read 0, writes ignored. Writes to RO registers are ignored.

Counter and timer:
- Counter is 16 bits, increments every cycle from 0 after reset, wraps 0xFFFF→0x0000.
- PEND sets when EN=1 and the counter low byte equals CMP.
- PEND set and a clear write in the same cycle: set wins.
- o_irq = EN & PEND.

UART FIFO:
- A push while full is dropped and sets overflow.
- Full is evaluated on the pre-cycle count, so a push while full is dropped even if the serializer pops in that cycle.

UART serializer (sub-module) states:
- IDLE → START when the FIFO is non-empty; pops the head byte.
- START → DATA after CLKS_PER_BIT cycles.
- DATA sends 8 bits LSB first, CLKS_PER_BIT cycles each, then → STOP.
- STOP → IDLE after CLKS_PER_BIT cycles.
- o_tx: 0 in START, data bit in DATA, 1 in STOP and IDLE.
- Frame length is 10·CLKS_PER_BIT cycles.

## Timing
- Read in cycle N: o_rsp_data valid from cycle N+1. It holds until the next read completes; writes and idle cycles leave it unchanged.
- Write in cycle N: visible to a read issued in cycle N+1 (RAM and registers).
- A read of CNT_LO in cycle N returns the counter value sampled in cycle N.
- FIFO push in cycle N: count visible at N+1. If the serializer is IDLE, o_tx falls at N+2.
- PEND set by a match in cycle N: o_irq high at N+1.
- Reset values:
  - o_rsp_data = 0x00, o_tx = 1, o_irq = 0.
  - Counter, shadow, CMP, TCTL, SCRATCH = 0.
  - FIFO empty, overflow = 0, serializer IDLE.
- Reset asserted mid-frame: o_tx goes to 1 immediately (asynchronously), the FIFO is flushed and the frame is abandoned.

## Configuration
H8_DMEM_UART_EN:
- Defined: FIFO and serializer are built as described.
- Undefined: no FIFO or serializer logic. TXDATA writes are ignored, TXSTAT reads 0, o_tx is tied to 1.
- Counter, timer and RAM are unaffected either way.

## Structure
- Shared package h8_dmem_pkg holds:
  - address constants (MMIO_BASE = 0xF0 and each register offset);
  - TCTL and TXSTAT bit positions;
  - the serializer state enum (IDLE, START, DATA, STOP).
- One sub-module, h8_uart_tx. It contains the serializer FSM, bit counter and baud counter, and takes a valid/ready byte input from the FIFO.
- The FIFO and decode stay in the top level.

## Test plan
- Write 0x5A to 0x10, read 0x10 next cycle → o_rsp_data = 0x5A one cycle after the read; a following idle cycle keeps 0x5A.
- Read 0xF0 at counter 0x01FF, stall 2 cycles, read 0xF1 → 0xFF then 0x01 (shadow, not the live byte). Run 65536 cycles and confirm wrap to 0x0000.
- CMP=0x40, TCTL=0x01 → o_irq rises one cycle after the low byte equals 0x40. Write TCTL=0x03 → o_irq drops. A clear in the same cycle as a match leaves PEND=1.
- CLKS_PER_BIT=4: write 0xA5 to 0xF8 → o_tx frame 0, 1,0,1,0,0,1,0,1, 1, each bit 4 cycles; TXSTAT busy during the frame, 0x00 after.
- Write 6 bytes back-to-back → first pops, 4 queued, 6th dropped. TXSTAT bit5 = 1; a second TXSTAT read shows bit5 = 0. The 5 accepted bytes are transmitted in order.
- Drop i_rst_n during DATA of a frame → o_tx = 1 immediately, TXSTAT = 0 after release, no further frame emitted.
